// File: rtl/if_fetch_buf.sv
// Instruction-fetch buffer: gates PC advance, reads sync IMEM, queues {inst,pc} for decode.
// Latency issue->out_valid 2 cycles; stalls PC when queue+in-flight is full; FETCH_STAT_EN adds stat_bubbles.
module if_fetch_buf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic              im_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]       stat_bubbles
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              busy;
    logic [ADDR_W-1:0] busy_pc;

    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reserving a slot for every in-flight read lets the memory run without backpressure.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, busy};
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = busy;
    assign issue     = !rst && !flush && ((occ < (CW + 1)'(DEPTH)) || pop);

    assign pc_en     = issue;
    assign im_en     = issue;
    assign im_addr   = pc;
    assign out_inst  = inst_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            busy    <= 1'b0;
            busy_pc <= '0;
        end else begin
            busy <= issue;
            if (issue) begin
                busy_pc <= pc;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            inst_q[wr_ptr] <= im_rdata;
            pc_q[wr_ptr]   <= busy_pc;
        end
    end

`ifdef FETCH_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bubbles <= '0;
        end else if (!out_valid) begin
            stat_bubbles <= stat_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf with a PC register and synchronous memory model around it.
module tb_if_fetch_buf;

    typedef struct packed {
        logic [31:0] inst;
        logic [9:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pc;
    logic        pc_en;
    logic        im_en;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [9:0]  out_pc;
    logic [31:0] stat_bubbles;
    logic [9:0]  tgt = '0;
    int          epoch = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    if_fetch_buf #(.ADDR_W(10), .DATA_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .im_en(im_en),
        .im_addr(im_addr), .im_rdata(im_rdata), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
`ifdef FETCH_STAT_EN
        , .stat_bubbles(stat_bubbles)
`endif
    );

`ifndef FETCH_STAT_EN
    assign stat_bubbles = '0;
`endif

    // PC register: redirect target loads on flush, otherwise advances on pc_en.
    always_ff @(posedge clk) begin
        if (rst)        pc <= '0;
        else if (flush) pc <= tgt;
        else if (pc_en) pc <= pc + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (im_en) im_rdata <= 32'h1000_0000 + 32'(epoch << 16) + 32'(im_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head entry must match the next expected one.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got pc %h inst %h expected nothing", out_pc, out_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_inst !== e.inst) begin
                    errors++;
                    $display("FAIL pop: got pc %h inst %h expected pc %h inst %h",
                             out_pc, out_inst, e.pc, e.inst);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        e.pc   = 10'(p);
        e.inst = 32'h1000_0000 + 32'(epoch << 16) + 32'(p);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        next();
        next();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_im_en", 32'(im_en), 32'd0);
`ifdef FETCH_STAT_EN
        chk("rst_stat", stat_bubbles, 32'd0);
`endif
        next();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            next();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] s0;

        // Streaming at full rate from reset.
        epoch = 0;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) push_exp(i);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stream_valid_c%0d", c), 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c == 0) chk("stream_pc_en_c0", 32'(pc_en), 32'd1);
            next();
        end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;

        // Decode back-pressure from cycle 0.
        epoch = 1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("bp_pc_en_c%0d", c), 32'(pc_en), (c < 2) ? 32'd1 : 32'd0);
            chk($sformatf("bp_addr_c%0d", c), 32'(im_addr), (c < 2) ? 32'(c) : 32'd2);
            next();
        end
        for (int i = 0; i < 4; i++) push_exp(i);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_pc_en", 32'(pc_en), 32'd1);
        chk("bp_resume_addr", 32'(im_addr), 32'd2);
        next();
        wait_empty("bp_drain");

        // Flush mid-stream with a word returning and the head being accepted.
        epoch = 2;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) push_exp(i);
        for (int c = 0; c < 5; c++) next();
        chk("fl_pre_pops", 32'(exp_q.size()), 32'd0);
        flush = 1'b1;
        tgt = 10'h040;
        @(negedge clk);
        chk("fl_pc_en", 32'(pc_en), 32'd0);
        chk("fl_im_en", 32'(im_en), 32'd0);
        next();
        flush = 1'b0;
        for (int i = 'h40; i < 'h43; i++) push_exp(i);
        @(negedge clk);
        chk("fl_valid_c1", 32'(out_valid), 32'd0);
        chk("fl_addr_c1", 32'(im_addr), 32'h40);
        chk("fl_pc_en_c1", 32'(pc_en), 32'd1);
        next();
        @(negedge clk);
        chk("fl_valid_c2", 32'(out_valid), 32'd0);
        next();
        @(negedge clk);
        chk("fl_valid_c3", 32'(out_valid), 32'd1);
        chk("fl_out_pc_c3", 32'(out_pc), 32'h40);
        next();
        wait_empty("fl_drain");

        // Bubble counting across a flush followed by back-pressure.
        epoch = 3;
        out_ready = 1'b1;
        do_reset();
        push_exp(0);
        push_exp(1);
        for (int c = 0; c < 4; c++) next();
        flush = 1'b1;
        tgt = 10'h080;
        next();
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        s0 = stat_bubbles;
        for (int c = 0; c < 5; c++) next();
        @(negedge clk);
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_head_pc", 32'(out_pc), 32'h80);
`ifdef FETCH_STAT_EN
        chk("st_bubbles", stat_bubbles, s0 + 32'd2);
`endif
        push_exp('h80);
        push_exp('h81);
        out_ready = 1'b1;
        next();
        wait_empty("st_drain");

        // Reset mid-stream with a full queue.
        epoch = 4;
        do_reset();
        for (int c = 0; c < 4; c++) next();
        @(negedge clk);
        chk("mr_full_valid", 32'(out_valid), 32'd1);
        chk("mr_full_pc", 32'(out_pc), 32'd0);
        next();
        rst = 1'b1;
        out_ready = 1'b1;
        epoch = 5;
        next();
        @(negedge clk);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_pc_en", 32'(pc_en), 32'd0);
        chk("mr_im_en", 32'(im_en), 32'd0);
`ifdef FETCH_STAT_EN
        chk("mr_stat", stat_bubbles, 32'd0);
`endif
        next();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(i);
        @(negedge clk);
        chk("mr_valid_c0", 32'(out_valid), 32'd0);
        next();
        @(negedge clk);
        chk("mr_valid_c1", 32'(out_valid), 32'd0);
        next();
        wait_empty("mr_drain");
        next();
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_buf.md
# if_fetch_buf

Instruction-fetch buffer sitting directly downstream of the synchronous program counter. Each cycle it decides whether the PC may advance, issues the current PC to the synchronous instruction memory, captures the returned word one cycle later, and queues it with its PC for the decode stage over a valid/ready handshake. A flush input discards every in-flight and queued instruction on a branch/jump redirect.

## Interface
- ADDR_W, 10: instruction-memory word-address width; matches the PC width.
- DATA_W, 32: instruction width.
- DEPTH, 2: queue entries; legal values 2..8.

- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- pc  input  ADDR_W  current PC from the PC register.
- pc_en  output  1  advance PC this cycle; drives the PC enable.
- im_en  output  1  instruction-memory read strobe.
- im_addr  output  ADDR_W  memory word address; always equals pc.
- im_rdata  input  DATA_W  memory data, valid the cycle after im_en.
- flush  input  1  discard all in-flight and queued instructions.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head entry.
- out_inst  output  DATA_W  head instruction.
- out_pc  output  ADDR_W  head instruction word address.
- stat_bubbles  output  32  present only with FETCH_STAT_EN; see Configuration.

## Operation
- State: circular queue of DEPTH entries {inst, pc}, with read pointer, write pointer and count (0..DEPTH); one in-flight register {busy, pc}.
- pop = out_valid & out_ready.
- issue = !rst & !flush & ((count + busy < DEPTH) | pop).
- im_en = pc_en = issue. The top level ORs flush into the PC enable so that the redirect target loads while this block is idle.
- On issue, the in-flight register latches busy=1 and pc. With no issue, busy clears.
- When busy=1 at a rising edge and flush=0, {im_rdata, inflight.pc} is written at the write pointer.
- Push and pop in the same cycle are legal at any count. Count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH; the issue rule guarantees space for every returning word.
- out_valid = (count != 0). out_inst and out_pc come from the head entry. Data at the head is stable while out_valid=1 and out_ready=0.
- Flush (flush=1 at an edge) forces count=0, pointers=0 and busy=0. The im_rdata arriving on the following cycle belongs to the killed fetch and is ignored. Flush takes priority over push, pop and issue in the same cycle.
- Reset behaves like flush and also clears the stat counter.

## Timing
- Reset values: out_valid=0, pc_en=0, im_en=0, busy=0, count=0, stat_bubbles=0.
- Issue→out_valid latency: issue in cycle t, data captured at the end of t+1, out_valid=1 in t+2. There is no bypass path.
- Throughput: 1 instruction/cycle sustained while out_ready=1, using the pop term in issue.
- After flush is deasserted, the first issue occurs in the same cycle, and out_valid follows 2 cycles later.
- Decode back-pressure: with out_ready=0, issues continue until count+busy=DEPTH, then pc_en=0 and the PC holds.
- There is no combinational path from im_rdata to any output.

## Configuration
- FETCH_STAT_EN defined:
  - Adds the stat_bubbles port.
  - stat_bubbles is a 32-bit counter incremented every cycle with rst=0 and out_valid=0.
  - It wraps from 0xFFFFFFFF to 0.
  - It is cleared only by rst; flush does not clear it.
- FETCH_STAT_EN undefined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Reset, then release with pc=0 and out_ready=1, where the memory returns word = 0x1000_0000+addr. Required: out_valid rises in cycle 2; then out_pc=0,1,2,… with out_inst=0x10000000,0x10000001,… every cycle.
- Hold out_ready=0 from cycle 0, DEPTH=2. Required: exactly 2 issues (pc_en pulses at pc=0 and 1), then pc_en=0. After out_ready=1, entries pc=0 and 1 pop in order and issuing resumes the same cycle.
- Assert flush for 1 cycle while count=2 and busy=1, and the top loads pc=0x40. Required: out_valid=0 the next cycle; the stale im_rdata is dropped; the first output is out_pc=0x40 two cycles after flush falls.
- Assert flush together with out_ready=1 and a returning word. Required: no entry popped or written; count=0.
- Assert rst mid-stream with count=2. Required: all outputs at their reset values the next cycle, and no stale entry appears afterwards.
- With FETCH_STAT_EN: hold out_ready=0 for 5 cycles after flush. Required: stat_bubbles increases by 2 (the two empty cycles before the first word lands), not by 5.
